// File: rtl/npc_pc_unit.sv
// Fetch-stage PC register and next-PC selector: resolves D-stage branches/jumps,
// exception entry and eret return into the next fetch address, and flags fetch AdEL.
module npc_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT  = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret_d,
  input  logic [31:0] epc,
  input  logic [2:0]  br_type,
  input  logic        cmp_eq,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_index,
  input  logic [31:0] d_rs_val,
  output logic [31:0] f_pc,
  output logic        f_exc_adel,
  output logic [4:0]  f_exc_code,
  output logic        f_bd,
  output logic        f_kill,
  output logic        redirect
);

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_J    = 3'd3,
    BR_JR   = 3'd4
  } br_type_e;

  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc_plus4;
  logic [31:0] d_pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] cf_target;
  logic [31:0] next_pc;
  logic        is_cf;
  logic        taken;

  // Sequential wrap from 32'hFFFF_FFFC to 0 is intentional; the range check flags it.
  assign pc_plus4   = f_pc + 32'd4;
  assign d_pc_plus4 = d_pc + 32'd4;
  assign br_offset  = {{14{d_imm16[15]}}, d_imm16, 2'b00};
  assign br_target  = d_pc_plus4 + br_offset;
  assign j_target   = {d_pc_plus4[31:28], d_index, 2'b00};

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    is_cf     = 1'b0;
    taken     = 1'b0;
    cf_target = pc_plus4;
    case (br_type)
      BR_BEQ: begin
        is_cf     = 1'b1;
        taken     = cmp_eq;
        cf_target = br_target;
      end
      BR_BNE: begin
        is_cf     = 1'b1;
        taken     = !cmp_eq;
        cf_target = br_target;
      end
      BR_J: begin
        is_cf     = 1'b1;
        taken     = 1'b1;
        cf_target = j_target;
      end
      BR_JR: begin
        is_cf     = 1'b1;
        taken     = 1'b1;
        cf_target = d_rs_val;
      end
      default: begin
        is_cf     = 1'b0;
        taken     = 1'b0;
        cf_target = pc_plus4;
      end
    endcase
  end

  // Exception entry beats a freeze; a frozen branch or eret is simply re-evaluated later.
  always_comb begin
    next_pc = pc_plus4;
    if (req)
      next_pc = EXC_ENTRY;
    else if (stall)
      next_pc = f_pc;
    else if (eret_d)
      next_pc = epc;
    else if (taken)
      next_pc = cf_target;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)
      f_pc <= RESET_PC;
    else
      f_pc <= next_pc;
  end

  assign redirect   = !reset && (req || (!stall && (eret_d || taken)));
  assign f_bd       = is_cf && !req;
  assign f_kill     = eret_d && !stall && !req;
  assign f_exc_adel = (f_pc[1:0] != 2'b00) || (f_pc < IM_BASE) || (f_pc > IM_LIMIT);
  assign f_exc_code = f_exc_adel ? EXC_ADEL : 5'd0;

endmodule

// File: tb/tb_npc_pc_unit.sv
// Self-checking bench for npc_pc_unit: directed literal cases plus randomized
// stimulus compared every cycle against a behavioural next-PC model.
module tb_npc_pc_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT  = 32'h0000_6ffc;

  logic        clk = 1'b0;
  logic        reset, stall, req, eret_d, cmp_eq;
  logic [31:0] epc, d_pc, d_rs_val;
  logic [2:0]  br_type;
  logic [15:0] d_imm16;
  logic [25:0] d_index;
  logic [31:0] f_pc;
  logic        f_exc_adel, f_bd, f_kill, redirect;
  logic [4:0]  f_exc_code;

  int checks   = 0;
  int failures = 0;

  npc_pc_unit #(
    .RESET_PC(RESET_PC), .EXC_ENTRY(EXC_ENTRY), .IM_BASE(IM_BASE), .IM_LIMIT(IM_LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .eret_d(eret_d), .epc(epc),
    .br_type(br_type), .cmp_eq(cmp_eq), .d_pc(d_pc), .d_imm16(d_imm16),
    .d_index(d_index), .d_rs_val(d_rs_val), .f_pc(f_pc), .f_exc_adel(f_exc_adel),
    .f_exc_code(f_exc_code), .f_bd(f_bd), .f_kill(f_kill), .redirect(redirect)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  bit          m_valid = 0;

  function automatic bit m_is_cf(input logic [2:0] t);
    return (t >= 3'd1) && (t <= 3'd4);
  endfunction

  function automatic bit m_taken();
    if (br_type == 3'd1) return cmp_eq == 1'b1;
    if (br_type == 3'd2) return cmp_eq == 1'b0;
    return br_type == 3'd3 || br_type == 3'd4;
  endfunction

  function automatic logic [31:0] m_target();
    int off;
    off = int'($signed(d_imm16)) * 4;
    if (br_type == 3'd1 || br_type == 3'd2) return 32'(d_pc + 32'd4 + 32'(off));
    if (br_type == 3'd3) return ((d_pc + 32'd4) & 32'hF000_0000) | (32'(d_index) * 32'd4);
    return d_rs_val;
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc);
    if (reset)       return RESET_PC;
    if (req)         return EXC_ENTRY;
    if (stall)       return pc;
    if (eret_d)      return epc;
    if (m_taken())   return m_target();
    return 32'(pc + 32'd4);
  endfunction

  function automatic bit m_adel(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < IM_BASE) || (pc > IM_LIMIT);
  endfunction

  always @(posedge clk) begin
    m_pc    <= m_next(m_pc);
    if (reset) m_valid <= 1'b1;
  end

  // Compare process: on every falling edge once the model is seeded.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_f_pc", f_pc, m_pc);
      check("model_adel", {31'b0, f_exc_adel}, {31'b0, m_adel(m_pc)});
      check("model_code", {27'b0, f_exc_code}, m_adel(m_pc) ? 32'd4 : 32'd0);
      check("model_bd", {31'b0, f_bd}, {31'b0, m_is_cf(br_type) && !req});
      check("model_kill", {31'b0, f_kill}, {31'b0, eret_d && !stall && !req});
      check("model_redirect", {31'b0, redirect},
            {31'b0, !reset && (req || (!stall && (eret_d || m_taken())))});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; stall = 0; req = 0; eret_d = 0; br_type = 3'd0; cmp_eq = 0;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    idle();
    epc = 0; d_pc = 0; d_imm16 = 0; d_index = 0; d_rs_val = 0;
    reset = 1;
    step();
    reset = 0;
    settle();
    check("reset_pc", f_pc, 32'h3000);
    check("reset_redirect", {31'b0, redirect}, 32'd0);
    check("reset_adel", {31'b0, f_exc_adel}, 32'd0);
    check("reset_bd", {31'b0, f_bd}, 32'd0);
    check("reset_kill", {31'b0, f_kill}, 32'd0);
    step(); check("seq1", f_pc, 32'h3004);
    step(); check("seq2", f_pc, 32'h3008);
    step(); check("seq3", f_pc, 32'h300c);

    // beq taken backwards, then not taken
    d_pc = 32'h3010; br_type = 3'd1; cmp_eq = 1; d_imm16 = 16'hfffc;
    settle();
    check("beq_bd", {31'b0, f_bd}, 32'd1);
    check("beq_redirect", {31'b0, redirect}, 32'd1);
    step(); check("beq_target", f_pc, 32'h3004);
    cmp_eq = 0;
    settle();
    check("beq_nt_redirect", {31'b0, redirect}, 32'd0);
    check("beq_nt_bd", {31'b0, f_bd}, 32'd1);
    step(); check("beq_nt_pc", f_pc, 32'h3008);

    // j with region from d_pc+4, then jr to a misaligned address
    d_pc = 32'h3ffc; br_type = 3'd3; d_index = 26'h0000c20;
    step(); check("j_target", f_pc, 32'h0000_3080);
    br_type = 3'd4; d_rs_val = 32'h3001;
    step(); check("jr_target", f_pc, 32'h3001);
    br_type = 3'd0;
    settle();
    check("jr_adel", {31'b0, f_exc_adel}, 32'd1);
    check("jr_code", {27'b0, f_exc_code}, 32'd4);

    // jr held by stall, resolved once stall drops
    br_type = 3'd4; d_rs_val = 32'h3100; stall = 1;
    settle();
    check("stall_redirect", {31'b0, redirect}, 32'd0);
    step(); check("stall_hold1", f_pc, 32'h3001);
    step(); check("stall_hold2", f_pc, 32'h3001);
    stall = 0;
    settle();
    check("unstall_redirect", {31'b0, redirect}, 32'd1);
    step(); check("unstall_jr", f_pc, 32'h3100);

    // eret, then req beating everything
    br_type = 3'd0; eret_d = 1; epc = 32'h3050;
    settle();
    check("eret_kill", {31'b0, f_kill}, 32'd1);
    step(); check("eret_pc", f_pc, 32'h3050);
    req = 1; stall = 1; br_type = 3'd1; cmp_eq = 1;
    settle();
    check("req_kill", {31'b0, f_kill}, 32'd0);
    check("req_bd", {31'b0, f_bd}, 32'd0);
    check("req_redirect", {31'b0, redirect}, 32'd1);
    step(); check("req_pc", f_pc, 32'h4180);
    idle();

    // upper limit crossing
    br_type = 3'd4; d_rs_val = 32'h6ffc;
    step(); check("limit_pc", f_pc, 32'h6ffc);
    br_type = 3'd0;
    settle();
    check("limit_adel", {31'b0, f_exc_adel}, 32'd0);
    step(); check("over_pc", f_pc, 32'h7000);
    check("over_adel", {31'b0, f_exc_adel}, 32'd1);

    // reset mid-stall with a pending jr and a req
    stall = 1; br_type = 3'd4; d_rs_val = 32'h3200;
    step();
    reset = 1; req = 1;
    settle();
    check("reset_blocks_redirect", {31'b0, redirect}, 32'd0);
    step();
    idle();
    check("reset_mid_stall", f_pc, 32'h3000);

    // sequential wrap at the top of the address space
    br_type = 3'd4; d_rs_val = 32'hffff_fffc;
    step(); br_type = 3'd0;
    step(); check("wrap_pc", f_pc, 32'h0000_0000);
    check("wrap_adel", {31'b0, f_exc_adel}, 32'd1);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 63) == 0);
      req      = ($urandom_range(0, 15) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      eret_d   = ($urandom_range(0, 15) == 0);
      br_type  = 3'($urandom_range(0, 7));
      cmp_eq   = 1'($urandom);
      epc      = ($urandom_range(0, 1) == 0) ? (32'h3000 + 32'($urandom_range(0, 4095)) * 4) : $urandom;
      d_pc     = ($urandom_range(0, 3) == 0) ? $urandom : f_pc - 32'd4;
      d_imm16  = 16'($urandom);
      d_index  = 26'($urandom);
      d_rs_val = ($urandom_range(0, 3) == 0) ? $urandom : (32'h3000 + 32'($urandom_range(0, 4200)) * 4);
      step();
    end
    idle();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
